// File: rtl/bank_htu_pkg.sv
// Shared constants and FSM encoding for the bank HTU miss-allocation path.
package bank_htu_pkg;

  localparam int HTU_WAYS  = 8;
  localparam int HTU_SET_W = 6;
  localparam int HTU_TAG_W = 20;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_EVICT  = 3'd2,
    ST_REFILL = 3'd3,
    ST_WAIT   = 3'd4,
    ST_UPDATE = 3'd5
  } htu_state_e;

endpackage

// File: rtl/bank_htu_victim_pick.sv
// Combinational victim choice: unlocked invalid way first, then unlocked PLRU way,
// then lowest unlocked way; fail when every way is locked.
module bank_htu_victim_pick
  import bank_htu_pkg::*;
#(
  parameter int WAYS = HTU_WAYS
) (
  input  logic [WAYS-1:0] valid_i,
  input  logic [WAYS-1:0] oldest_i,
  input  logic [WAYS-1:0] lock_i,
  output logic [WAYS-1:0] victim_o,
  output logic            fail_o
);

  logic [WAYS-1:0] w_open;
  logic [WAYS-1:0] w_free;
  logic [WAYS-1:0] w_old;

  function automatic logic [WAYS-1:0] lowest_one(input logic [WAYS-1:0] m);
    lowest_one = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (m[i]) begin
        lowest_one    = '0;
        lowest_one[i] = 1'b1;
      end
    end
  endfunction

  assign w_open = ~lock_i;
  assign w_free = ~valid_i & w_open;
  assign w_old  = oldest_i & w_open;

  // A malformed (multi-hot or empty) PLRU mask collapses to a single way here.
  always_comb begin
    victim_o = '0;
    fail_o   = 1'b0;
    if (~|w_open)
      fail_o = 1'b1;
    else if (|w_free)
      victim_o = lowest_one(w_free);
    else if (|w_old)
      victim_o = lowest_one(w_old);
    else
      victim_o = lowest_one(w_open);
  end

endmodule

// File: rtl/bank_htu_victim_alloc.sv
// Miss-allocation controller: victim pick, dirty eviction, refill, PLRU access pulse.
// Optional way locking is compiled in with `define BANK_HTU_WAY_LOCK_EN.
module bank_htu_victim_alloc
  import bank_htu_pkg::*;
#(
  parameter int WAYS  = HTU_WAYS,
  parameter int SET_W = HTU_SET_W,
  parameter int TAG_W = HTU_TAG_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  miss_valid_i,
  output logic                  miss_ready_o,
  input  logic [SET_W-1:0]      miss_set_i,
  input  logic [TAG_W-1:0]      miss_tag_i,
  input  logic [WAYS-1:0]       way_valid_array_i,
  input  logic [WAYS-1:0]       way_dirty_array_i,
  input  logic [WAYS*TAG_W-1:0] way_tag_flat_i,
  input  logic [WAYS-1:0]       oldest_way_array_i,
`ifdef BANK_HTU_WAY_LOCK_EN
  input  logic [WAYS-1:0]       way_lock_array_i,
  output logic                  alloc_fail_o,
`endif
  output logic                  evict_valid_o,
  input  logic                  evict_ready_i,
  output logic [SET_W-1:0]      evict_set_o,
  output logic [TAG_W-1:0]      evict_tag_o,
  output logic                  refill_req_valid_o,
  input  logic                  refill_req_ready_i,
  output logic [SET_W-1:0]      refill_set_o,
  output logic [TAG_W-1:0]      refill_tag_o,
  input  logic                  refill_done_i,
  output logic [WAYS-1:0]       alloc_way_array_o,
  output logic [WAYS-1:0]       alloc_access_array_o,
  output logic                  alloc_done_o
);

  htu_state_e r_state, w_state_nxt;

  logic [SET_W-1:0]      r_set;
  logic [TAG_W-1:0]      r_tag;
  logic [WAYS-1:0]       r_valid;
  logic [WAYS-1:0]       r_dirty;
  logic [WAYS*TAG_W-1:0] r_tag_flat;
  logic [WAYS-1:0]       r_victim;
  logic [TAG_W-1:0]      r_victim_tag;

  logic [WAYS-1:0]       w_lock;
  logic [WAYS-1:0]       w_victim;
  logic                  w_fail;
  logic                  w_victim_dirty;
  logic [TAG_W-1:0]      w_victim_tag;

`ifdef BANK_HTU_WAY_LOCK_EN
  assign w_lock       = way_lock_array_i;
  assign alloc_fail_o = (r_state == ST_SELECT) && w_fail;
`else
  assign w_lock = '0;
`endif

  bank_htu_victim_pick #(.WAYS(WAYS)) u_pick (
    .valid_i  (r_valid),
    .oldest_i (oldest_way_array_i),
    .lock_i   (w_lock),
    .victim_o (w_victim),
    .fail_o   (w_fail)
  );

  // Only a line that is both valid and dirty needs writing back.
  assign w_victim_dirty = |(w_victim & r_valid & r_dirty);

  always_comb begin
    w_victim_tag = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (w_victim[w]) w_victim_tag = w_victim_tag | r_tag_flat[w*TAG_W +: TAG_W];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (r_state == ST_IDLE && miss_valid_i) begin
      r_set      <= miss_set_i;
      r_tag      <= miss_tag_i;
      r_valid    <= way_valid_array_i;
      r_dirty    <= way_dirty_array_i;
      r_tag_flat <= way_tag_flat_i;
    end
    if (r_state == ST_SELECT) begin
      r_victim     <= w_victim;
      r_victim_tag <= w_victim_tag;
    end
  end

  always_comb begin
    w_state_nxt          = r_state;
    miss_ready_o         = 1'b0;
    evict_valid_o        = 1'b0;
    refill_req_valid_o   = 1'b0;
    alloc_way_array_o    = '0;
    alloc_access_array_o = '0;
    alloc_done_o         = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        miss_ready_o = 1'b1;
        if (miss_valid_i) w_state_nxt = ST_SELECT;
      end
      ST_SELECT: begin
        alloc_way_array_o = w_victim;
        if (w_fail)              w_state_nxt = ST_IDLE;
        else if (w_victim_dirty) w_state_nxt = ST_EVICT;
        else                     w_state_nxt = ST_REFILL;
      end
      ST_EVICT: begin
        alloc_way_array_o = r_victim;
        evict_valid_o     = 1'b1;
        if (evict_ready_i) w_state_nxt = ST_REFILL;
      end
      ST_REFILL: begin
        alloc_way_array_o  = r_victim;
        refill_req_valid_o = 1'b1;
        if (refill_req_ready_i) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        alloc_way_array_o = r_victim;
        if (refill_done_i) w_state_nxt = ST_UPDATE;
      end
      ST_UPDATE: begin
        alloc_way_array_o    = r_victim;
        alloc_access_array_o = r_victim;
        alloc_done_o         = 1'b1;
        w_state_nxt          = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Address fields are gated so they read zero whenever the request is idle.
  assign evict_set_o  = evict_valid_o      ? r_set        : '0;
  assign evict_tag_o  = evict_valid_o      ? r_victim_tag : '0;
  assign refill_set_o = refill_req_valid_o ? r_set        : '0;
  assign refill_tag_o = refill_req_valid_o ? r_tag        : '0;

endmodule

// File: tb/tb_bank_htu_victim_alloc.sv
// Scoreboard bench for bank_htu_victim_alloc; lock cases run when BANK_HTU_WAY_LOCK_EN is defined.
module tb_bank_htu_victim_alloc;

  localparam int WAYS  = 8;
  localparam int SET_W = 6;
  localparam int TAG_W = 20;

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic                  miss_valid_i;
  logic                  miss_ready_o;
  logic [SET_W-1:0]      miss_set_i;
  logic [TAG_W-1:0]      miss_tag_i;
  logic [WAYS-1:0]       way_valid_array_i;
  logic [WAYS-1:0]       way_dirty_array_i;
  logic [WAYS*TAG_W-1:0] way_tag_flat_i;
  logic [WAYS-1:0]       oldest_way_array_i;
  logic [WAYS-1:0]       cur_lock;
  logic                  evict_valid_o;
  logic                  evict_ready_i;
  logic [SET_W-1:0]      evict_set_o;
  logic [TAG_W-1:0]      evict_tag_o;
  logic                  refill_req_valid_o;
  logic                  refill_req_ready_i;
  logic [SET_W-1:0]      refill_set_o;
  logic [TAG_W-1:0]      refill_tag_o;
  logic                  refill_done_i;
  logic [WAYS-1:0]       alloc_way_array_o;
  logic [WAYS-1:0]       alloc_access_array_o;
  logic                  alloc_done_o;
`ifdef BANK_HTU_WAY_LOCK_EN
  logic                  alloc_fail_o;
`endif

  always #5 clk_i = ~clk_i;

  bank_htu_victim_alloc #(.WAYS(WAYS), .SET_W(SET_W), .TAG_W(TAG_W)) dut (
    .clk_i                (clk_i),
    .rst_i                (rst_i),
    .miss_valid_i         (miss_valid_i),
    .miss_ready_o         (miss_ready_o),
    .miss_set_i           (miss_set_i),
    .miss_tag_i           (miss_tag_i),
    .way_valid_array_i    (way_valid_array_i),
    .way_dirty_array_i    (way_dirty_array_i),
    .way_tag_flat_i       (way_tag_flat_i),
    .oldest_way_array_i   (oldest_way_array_i),
`ifdef BANK_HTU_WAY_LOCK_EN
    .way_lock_array_i     (cur_lock),
    .alloc_fail_o         (alloc_fail_o),
`endif
    .evict_valid_o        (evict_valid_o),
    .evict_ready_i        (evict_ready_i),
    .evict_set_o          (evict_set_o),
    .evict_tag_o          (evict_tag_o),
    .refill_req_valid_o   (refill_req_valid_o),
    .refill_req_ready_i   (refill_req_ready_i),
    .refill_set_o         (refill_set_o),
    .refill_tag_o         (refill_tag_o),
    .refill_done_i        (refill_done_i),
    .alloc_way_array_o    (alloc_way_array_o),
    .alloc_access_array_o (alloc_access_array_o),
    .alloc_done_o         (alloc_done_o)
  );

  typedef struct {
    logic [WAYS-1:0]  way;
    int               ev_n;
    logic [TAG_W-1:0] ev_tag;
    logic [TAG_W-1:0] tag;
    logic [SET_W-1:0] set;
    int               lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference victim choice written straight from the selection rules.
  function automatic logic [WAYS-1:0] ref_pick(input logic [WAYS-1:0] vld,
                                                input logic [WAYS-1:0] old,
                                                input logic [WAYS-1:0] lck);
    for (int i = 0; i < WAYS; i++) if (!vld[i] && !lck[i]) return 8'(1 << i);
    for (int i = 0; i < WAYS; i++) if (old[i] && !lck[i])  return 8'(1 << i);
    for (int i = 0; i < WAYS; i++) if (!lck[i])            return 8'(1 << i);
    return '0;
  endfunction

  // Output monitor: pops the scoreboard on each completed allocation.
  int               cyc = 0;
  int               t_start = 0;
  int               ev_n = 0;
  bit               rf_seen = 0;
  logic [TAG_W-1:0] ev_tag, rf_tag;
  logic [SET_W-1:0] ev_set, rf_set;
  exp_t             m_e;

  always @(negedge clk_i) begin
    cyc++;
    if (!rst_i) begin
      if (miss_valid_i && miss_ready_o) begin
        t_start = cyc;
        ev_n    = 0;
        rf_seen = 0;
      end
      if (evict_valid_o) begin
        ev_n++;
        ev_tag = evict_tag_o;
        ev_set = evict_set_o;
      end
      if (refill_req_valid_o) begin
        rf_seen = 1;
        rf_tag  = refill_tag_o;
        rf_set  = refill_set_o;
      end
      if (alloc_done_o) begin
        if (sb.size() == 0) chk_eq("spurious_done", 1, 0);
        else begin
          m_e = sb.pop_front();
          chk_eq("alloc_way", alloc_way_array_o, m_e.way);
          chk_eq("alloc_access", alloc_access_array_o, m_e.way);
          chk_eq("latency", cyc - t_start, m_e.lat);
          chk_eq("evict_cycles", ev_n, m_e.ev_n);
          if (m_e.ev_n > 0) begin
            chk_eq("evict_tag", ev_tag, m_e.ev_tag);
            chk_eq("evict_set", ev_set, m_e.set);
          end
          chk_eq("refill_seen", rf_seen, 1);
          chk_eq("refill_tag", rf_tag, m_e.tag);
          chk_eq("refill_set", rf_set, m_e.set);
        end
      end else begin
        chk_eq("access_idle", alloc_access_array_o, 0);
      end
    end
  end

  task automatic run_miss(input logic [WAYS-1:0] vld, input logic [WAYS-1:0] dty,
                          input logic [WAYS-1:0] old, input int ev_stall,
                          input int done_dly, input bit hold_off,
                          input logic [WAYS-1:0] exp_way);
    exp_t e;
    int   vi = 0, ev_seen = 0, wcnt = 0;
    bit   waiting = 0, got_done = 0, hs = 0;
    bit   exp_ev;
    @(posedge clk_i); #1;
    chk_eq("idle_ready", miss_ready_o, 1);
    miss_set_i = SET_W'($urandom);
    miss_tag_i = TAG_W'($urandom);
    for (int w = 0; w < WAYS; w++) way_tag_flat_i[w*TAG_W +: TAG_W] = TAG_W'($urandom);
    for (int w = 0; w < WAYS; w++) if (exp_way[w]) vi = w;
    exp_ev   = |(exp_way & vld & dty);
    e.way    = exp_way;
    e.ev_n   = exp_ev ? ev_stall + 1 : 0;
    e.ev_tag = way_tag_flat_i[vi*TAG_W +: TAG_W];
    e.tag    = miss_tag_i;
    e.set    = miss_set_i;
    e.lat    = exp_ev ? 5 + ev_stall + done_dly : 4 + done_dly;
    sb.push_back(e);
    way_valid_array_i  = vld;
    way_dirty_array_i  = dty;
    oldest_way_array_i = old;
    evict_ready_i      = (ev_stall == 0);
    refill_req_ready_i = 1'b1;
    refill_done_i      = (done_dly == 0);
    miss_valid_i       = 1'b1;
    @(posedge clk_i); #1;
    miss_valid_i = 1'b0;
    for (int k = 0; k < 200 && !got_done; k++) begin
      if (alloc_done_o) got_done = 1;
      else begin
        if (evict_valid_o) begin
          evict_ready_i = (ev_seen >= ev_stall);
          ev_seen++;
        end
        if (waiting) begin
          refill_done_i = (wcnt >= done_dly);
          wcnt++;
          if (hold_off) begin
            miss_valid_i = 1'b1;
            chk_eq("hold_off_ready", miss_ready_o, 0);
          end
        end
        hs = refill_req_valid_o && refill_req_ready_i;
        @(posedge clk_i); #1;
        if (hs) waiting = 1;
      end
    end
    if (!got_done) chk_eq("done_timeout", 0, 1);
    miss_valid_i  = 1'b0;
    refill_done_i = 1'b0;
  endtask

  initial begin
    logic [WAYS-1:0] v, d, o;
    rst_i              = 1'b1;
    miss_valid_i       = 1'b0;
    miss_set_i         = '0;
    miss_tag_i         = '0;
    way_valid_array_i  = '0;
    way_dirty_array_i  = '0;
    way_tag_flat_i     = '0;
    oldest_way_array_i = '0;
    cur_lock           = '0;
    evict_ready_i      = 1'b0;
    refill_req_ready_i = 1'b0;
    refill_done_i      = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    chk_eq("rst_ready", miss_ready_o, 1);
    chk_eq("rst_evict", evict_valid_o, 0);
    chk_eq("rst_refill", refill_req_valid_o, 0);
    chk_eq("rst_way", alloc_way_array_o, 0);
    chk_eq("rst_done", alloc_done_o, 0);

    run_miss(8'hFF, 8'h00, 8'h20, 0, 0, 0, 8'h20);
    run_miss(8'hF3, 8'h00, 8'h01, 0, 0, 0, 8'h04);
    run_miss(8'hFF, 8'h80, 8'h80, 3, 0, 0, 8'h80);
    run_miss(8'hFF, 8'h00, 8'h02, 0, 10, 1, 8'h02);
    run_miss(8'hFF, 8'hFF, 8'h0C, 0, 0, 0, 8'h04);
    run_miss(8'hFF, 8'h00, 8'h00, 0, 0, 0, 8'h01);
    run_miss(8'hFE, 8'h01, 8'h40, 0, 0, 0, 8'h01);
    run_miss(8'h7F, 8'hFF, 8'h01, 0, 0, 0, 8'h80);

    // Reset while waiting for refill data: no allocation may complete.
    @(posedge clk_i); #1;
    way_valid_array_i  = 8'hFF;
    way_dirty_array_i  = 8'h00;
    oldest_way_array_i = 8'h08;
    refill_req_ready_i = 1'b1;
    refill_done_i      = 1'b0;
    miss_valid_i       = 1'b1;
    @(posedge clk_i); #1 miss_valid_i = 1'b0;
    @(posedge clk_i); #1 chk_eq("pre_rst_refill", refill_req_valid_o, 1);
    @(posedge clk_i); #1 rst_i = 1'b1;
    @(posedge clk_i); #1 rst_i = 1'b0;
    chk_eq("rst_wait_ready", miss_ready_o, 1);
    chk_eq("rst_wait_done", alloc_done_o, 0);
    refill_done_i = 1'b1;
    @(posedge clk_i); #1 refill_done_i = 1'b0;
    chk_eq("rst_wait_nodone", alloc_done_o, 0);

    // Reset during a stalled eviction drops the request next cycle.
    way_dirty_array_i  = 8'h08;
    evict_ready_i      = 1'b0;
    miss_valid_i       = 1'b1;
    @(posedge clk_i); #1 miss_valid_i = 1'b0;
    @(posedge clk_i); #1 chk_eq("pre_rst_evict", evict_valid_o, 1);
    rst_i = 1'b1;
    @(posedge clk_i); #1 rst_i = 1'b0;
    chk_eq("rst_evict_drop", evict_valid_o, 0);
    chk_eq("rst_evict_ready", miss_ready_o, 1);

    for (int n = 0; n < 6; n++) begin
      v = WAYS'($urandom);
      d = WAYS'($urandom);
      o = WAYS'($urandom);
      run_miss(v, d, o, n % 3, n % 4, 0, ref_pick(v, o, cur_lock));
    end

`ifdef BANK_HTU_WAY_LOCK_EN
    @(posedge clk_i); #1;
    cur_lock          = 8'hFF;
    way_valid_array_i = 8'hFF;
    miss_valid_i      = 1'b1;
    @(posedge clk_i); #1 miss_valid_i = 1'b0;
    chk_eq("lock_fail_pulse", alloc_fail_o, 1);
    chk_eq("lock_fail_way", alloc_way_array_o, 0);
    @(posedge clk_i); #1;
    chk_eq("lock_fail_clear", alloc_fail_o, 0);
    chk_eq("lock_fail_ready", miss_ready_o, 1);
    chk_eq("lock_fail_evict", evict_valid_o, 0);
    chk_eq("lock_fail_refill", refill_req_valid_o, 0);
    cur_lock = 8'h20;
    run_miss(8'hFF, 8'h00, 8'h20, 0, 0, 0, 8'h01);
    cur_lock = 8'h0F;
    run_miss(8'hF0, 8'h10, 8'h10, 1, 0, 0, 8'h10);
    cur_lock = 8'h00;
`endif

    repeat (3) @(posedge clk_i);
    #1 chk_eq("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bank_htu_victim_alloc.md
Name: bank_htu_victim_alloc

Overview:
Miss-allocation controller in the bank HTU, directly downstream of the 8-way PLRU tree.
- Accepts one tag miss at a time.
- Chooses a victim way: invalid ways first, otherwise the PLRU oldest way.
- Sequences dirty-line eviction and the refill request.
- On completion, drives a one-cycle one-hot access pulse back into the PLRU tree's access input, so the allocated way becomes most recently used.

Parameters:
WAYS, 8, number of ways; must equal PLRU tree width.
SET_W, 6, set index width.
TAG_W, 20, tag width.

Ports:
clk_i  input  1  clock.
rst_i  input  1  reset; synchronous, active-high.
miss_valid_i  input  1  miss request valid.
miss_ready_o  output  1  controller idle, can accept a miss.
miss_set_i  input  SET_W  set index of the miss.
miss_tag_i  input  TAG_W  tag of the missing line.
way_valid_array_i  input  WAYS  line-valid bits of the addressed set.
way_dirty_array_i  input  WAYS  line-dirty bits of the addressed set.
way_tag_flat_i  input  WAYS*TAG_W  stored tags of the addressed set; way w occupies bits [w*TAG_W +: TAG_W].
oldest_way_array_i  input  WAYS  one-hot oldest way from the PLRU tree.
evict_valid_o  output  1  dirty victim writeback request.
evict_ready_i  input  1  writeback accepted.
evict_set_o  output  SET_W  victim set.
evict_tag_o  output  TAG_W  victim tag.
refill_req_valid_o  output  1  refill request.
refill_req_ready_i  input  1  refill request accepted.
refill_set_o  output  SET_W  refill set.
refill_tag_o  output  TAG_W  refill tag.
refill_done_i  input  1  refill data written, single-cycle pulse.
alloc_way_array_o  output  WAYS  one-hot victim way; held from SELECT through UPDATE.
alloc_access_array_o  output  WAYS  one-cycle access pulse to the PLRU tree.
alloc_done_o  output  1  allocation complete, one-cycle pulse.

Behaviour:
- Reset: all registered outputs 0; state IDLE; miss_ready_o = 1 in the first cycle after reset.
- Reset mid-operation:
  - Returns to IDLE.
  - evict/refill valids drop in the next cycle.
  - No alloc pulse is generated.
- miss_ready_o = (state == IDLE).
- FSM states: IDLE, SELECT, EVICT, REFILL, WAIT, UPDATE.
- IDLE:
  - On miss_valid_i & miss_ready_o: register set, tag, valid/dirty arrays and tag_flat.
  - Next state SELECT.
- SELECT (always exactly 1 cycle):
  - If any registered valid bit is 0, victim = lowest-index invalid way.
  - Otherwise victim = oldest_way_array_i, sampled in this cycle.
  - If oldest_way_array_i is not one-hot, use its lowest set bit. If it is all-zero, use way 0.
  - Register victim one-hot, plus victim dirty and victim tag.
  - Next state EVICT if victim is valid & dirty, else REFILL.
- EVICT:
  - evict_valid_o = 1; set/tag held stable until evict_ready_i.
  - Next state REFILL in the cycle after the handshake.
- REFILL:
  - refill_req_valid_o = 1 with stable set/tag until refill_req_ready_i.
  - Next state WAIT.
- WAIT:
  - Wait for refill_done_i, then go to UPDATE.
  - refill_done_i in any other state is ignored.
- UPDATE (exactly 1 cycle):
  - alloc_access_array_o = victim one-hot.
  - alloc_done_o = 1.
  - Next state IDLE; a new miss can be accepted in the following cycle.
- Latency, with accept in cycle 0 and all ready/done inputs held high: clean victim pulses in cycle 4; dirty victim pulses in cycle 5.
- alloc_access_array_o is 0 in every state except UPDATE.
- No output is ever multi-hot.

Optional Feature:
BANK_HTU_WAY_LOCK_EN
- Enabled:
  - Adds input way_lock_array_i (WAYS) and output alloc_fail_o (1).
  - Locked ways are excluded from both the invalid-first pick and the PLRU pick.
  - If the PLRU way is locked, the fallback is the lowest-index unlocked way.
  - If all ways are locked: SELECT goes directly to IDLE, alloc_fail_o pulses for 1 cycle, and no evict, refill or access pulse is issued.
- Disabled: no extra ports; behaviour exactly as above.

Decomposition:
- Package bank_htu_pkg holds:
  - HTU_WAYS, HTU_SET_W, HTU_TAG_W constants.
  - The FSM state typedef with a fixed 3-bit encoding (IDLE=0, SELECT=1, EVICT=2, REFILL=3, WAIT=4, UPDATE=5).
- Sub-module bank_htu_victim_pick: combinational victim selection.
  - Inputs: valid, oldest and (optional) lock masks.
  - Outputs: one-hot victim and fail flag.

Test Plan:
- Clean PLRU victim: all valid, dirty=0x00, oldest=0x20, readies/done high → alloc_way_array_o=0x20, refill request issued, no evict, alloc_access_array_o=0x20 in cycle 4 only.
- Invalid-first: valid=0xF3, oldest=0x01 → victim 0x04 (way 2), no evict.
- Dirty victim with backpressure: oldest=0x80, dirty=0x80, evict_ready_i low 3 cycles → evict_valid_o held with tag of way 7 for 4 cycles; then refill; alloc pulse 0x80.
- Refill stall: refill_done_i delayed 10 cycles → alloc pulse exactly one cycle after done; miss_ready_o low throughout; a second miss held off.
- Reset in WAIT: rst_i high for 1 cycle → next cycle IDLE, miss_ready_o=1, no alloc_done_o.
- Lock (BANK_HTU_WAY_LOCK_EN defined): lock=0xFF → alloc_fail_o pulse, no requests. Lock=0x20 with oldest=0x20, all valid → victim 0x01.
